traffic_phase_sequencer: RTL and testbench
==========================================

Name: traffic_phase_sequencer

Overview:
- Drives the countdown interface from the control side: it issues the `loader` pulse to the 6-bit seconds countdown and consumes the `seconds` value that comes back.
- Steps an intersection through a fixed phase ring: NS green/yellow, all-red, EW green/yellow, all-red. An optional pedestrian walk phase is inserted on request, and an emergency input forces all-red.
- Sits between the seconds countdown and the light/LED output drivers.

Parameters:
- GREEN_END, 0, seconds value that ends a green phase (green lasts 16 ticks).
- YELLOW_END, 12, seconds value that ends a yellow phase (4 ticks).
- ALLRED_END, 14, seconds value that ends an all-red phase (2 ticks).
- WALK_END, 6, seconds value that ends the pedestrian walk phase (10 ticks).

Ports:
- InputClk  input  1  sequencer clock; all state updates on the posedge.
- reset  input  1  synchronous, active-high reset.
- seconds  input  6  remaining count from the countdown (reloads to 15; decrements each tick).
- ped_req  input  1  pedestrian request; level or pulse, latched internally.
- emergency  input  1  forces all-red while high.
- loader  output  1  reload strobe to the countdown; registered.
- ns_light  output  3  {red,yellow,green}, one-hot.
- ew_light  output  3  {red,yellow,green}, one-hot.
- walk  output  1  pedestrian walk lamp.
- phase  output  3  current state code, for debug/display.

Behaviour:
- Clocking and reset:
  - Single clock InputClk.
  - Reset is synchronous and active-high; it has priority over everything.
  - Reset values: state=ALL_RED_B, loader=1, armed=0, ped_latch=0, ns_light=ew_light=3'b100, walk=0, phase=5.
- State codes: NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_B=5, PED_WALK=6, EMERGENCY=7.
- Transitions:
  - NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW -> ALL_RED_B.
  - From ALL_RED_B: go to PED_WALK if ped_latch=1, else to NS_GREEN.
  - PED_WALK -> NS_GREEN.
- Exit condition: armed==1 and seconds==END for the current state (GREEN_END / YELLOW_END / ALLRED_END / WALK_END).
- Load handshake:
  - On the posedge that changes state, loader<=1 and armed<=0.
  - On the next posedge, loader<=0 and armed<=1.
  - loader is therefore exactly a 1-cycle pulse per phase entry. The countdown samples it on the intervening negedge, and armed masks the stale seconds value read during the load cycle.
- Phase duration: with armed, the cycle count from the load posedge to the exit posedge is 16 - END.
- Outputs: registered, decoded from the next state so they change on the same edge as the state.
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - ALL_RED_A, ALL_RED_B, EMERGENCY: both 100.
  - PED_WALK: both 100, walk=1.
  - walk=0 in every other state.
- Pedestrian latch:
  - ped_latch<=1 whenever ped_req=1.
  - Cleared on the posedge entering PED_WALK. If ped_req=1 on that same edge, the latch still clears (the request is served).
  - Unaffected by emergency.
- Emergency:
  - When sampled high and reset=0: state<=EMERGENCY, regardless of the exit condition on that edge. loader is held 1 every cycle, so the counter is pinned at 15. armed=0.
  - On the first posedge with emergency=0 while in EMERGENCY: state<=ALL_RED_B with a loader pulse, then the normal ring resumes.
- Priority: reset > emergency > phase exit.
- Width rule: END parameters must be ≤14; compare against the full 6 bits of seconds. If seconds>15 (illegal), treat it as not-equal; no other effect.

Decomposition:
- Shared package (traffic_pkg): state code localparams, light codes (RED=3'b100, YEL=3'b010, GRN=3'b001), default END values.
- One natural sub-module: traffic_light_decode, a combinational map from state to {ns_light, ew_light, walk}. The parent registers its outputs.

Test Plan:
- Reset released, countdown model attached (negedge, reload 15) -> loader low 1 cycle after reset. NS_GREEN entered at the second cycle post-reset (ALL_RED_B exits at seconds=14) with a loader pulse. ns_light=001 for 16 cycles.
- Free run, no requests -> repeating phase sequence 0,1,2,3,4,5 with lengths 16,4,2,16,4,2 cycles. Exactly one loader pulse per entry; lights never green/yellow on both axes at once.
- ped_req 1-cycle pulse during EW_GREEN -> after ALL_RED_B, PED_WALK for 10 cycles with walk=1 and both lights 100, then NS_GREEN. A second cycle through the ring has no walk.
- ped_req held high across PED_WALK entry -> latch clears on entry, then re-sets on the next cycle because ped_req is still high. A walk follows the next ALL_RED_B.
- emergency asserted mid NS_GREEN at seconds=7 -> next edge all-red, phase=7, loader=1 continuously. Release -> ALL_RED_B (2 cycles), then NS_GREEN.
- reset asserted during EW_YELLOW together with emergency=1 -> reset wins: phase=5, loader=1, lights 100/100, ped_latch=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase sequencer: phase codes, lamp codes
// and the default countdown values that end each phase.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6,
    EMERGENCY = 3'd7
  } phase_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // The countdown reloads to 15, so a phase lasts 16 - END ticks.
  localparam logic [5:0] GREEN_END_DEF  = 6'd0;
  localparam logic [5:0] YELLOW_END_DEF = 6'd12;
  localparam logic [5:0] ALLRED_END_DEF = 6'd14;
  localparam logic [5:0] WALK_END_DEF   = 6'd6;

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational map from a phase code to the two lamp heads and the walk lamp.
module traffic_light_decode
  import traffic_pkg::*;
(
  input  phase_t     state,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk
);

  always_comb begin
    ns_light = RED;
    ew_light = RED;
    walk     = 1'b0;
    case (state)
      NS_GREEN:  ns_light = GRN;
      NS_YELLOW: ns_light = YEL;
      EW_GREEN:  ew_light = GRN;
      EW_YELLOW: ew_light = YEL;
      PED_WALK:  walk     = 1'b1;
      default: begin
        ns_light = RED;
        ew_light = RED;
      end
    endcase
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Phase ring controller: steps the intersection through its phases, issuing a
// one-cycle loader strobe to the seconds countdown on every phase entry.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter logic [5:0] GREEN_END  = GREEN_END_DEF,
  parameter logic [5:0] YELLOW_END = YELLOW_END_DEF,
  parameter logic [5:0] ALLRED_END = ALLRED_END_DEF,
  parameter logic [5:0] WALK_END   = WALK_END_DEF
) (
  input  logic       InputClk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic       ped_req,
  input  logic       emergency,
  output logic       loader,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  phase_t     state;
  phase_t     state_nxt;
  logic       armed;
  logic       ped_latch;
  logic       load_nxt;
  logic       expired;
  logic [5:0] end_val;
  logic [2:0] ns_nxt;
  logic [2:0] ew_nxt;
  logic       walk_nxt;

  always_comb begin
    case (state)
      NS_GREEN, EW_GREEN:   end_val = GREEN_END;
      NS_YELLOW, EW_YELLOW: end_val = YELLOW_END;
      PED_WALK:             end_val = WALK_END;
      default:              end_val = ALLRED_END;
    endcase
  end

  // Full 6-bit compare: out-of-range seconds (>15) can never match an END value.
  assign expired = armed && (seconds == end_val);

  always_comb begin
    state_nxt = state;
    if (emergency) begin
      state_nxt = EMERGENCY;
    end else if (state == EMERGENCY) begin
      state_nxt = ALL_RED_B;
    end else if (expired) begin
      case (state)
        NS_GREEN:  state_nxt = NS_YELLOW;
        NS_YELLOW: state_nxt = ALL_RED_A;
        ALL_RED_A: state_nxt = EW_GREEN;
        EW_GREEN:  state_nxt = EW_YELLOW;
        EW_YELLOW: state_nxt = ALL_RED_B;
        ALL_RED_B: state_nxt = ped_latch ? PED_WALK : NS_GREEN;
        PED_WALK:  state_nxt = NS_GREEN;
        default:   state_nxt = state;
      endcase
    end
  end

  // Emergency keeps the strobe high so the countdown stays pinned at its reload value.
  assign load_nxt = (state_nxt != state) || (state_nxt == EMERGENCY);

  traffic_light_decode u_decode (
    .state    (state_nxt),
    .ns_light (ns_nxt),
    .ew_light (ew_nxt),
    .walk     (walk_nxt)
  );

  always_ff @(posedge InputClk) begin
    if (reset) begin
      state     <= ALL_RED_B;
      loader    <= 1'b1;
      armed     <= 1'b0;
      ped_latch <= 1'b0;
      ns_light  <= RED;
      ew_light  <= RED;
      walk      <= 1'b0;
    end else begin
      state    <= state_nxt;
      loader   <= load_nxt;
      armed    <= !load_nxt;
      ns_light <= ns_nxt;
      ew_light <= ew_nxt;
      walk     <= walk_nxt;
      // Entering the walk serves the request even if ped_req is still high.
      if (state_nxt == PED_WALK && state != PED_WALK)
        ped_latch <= 1'b0;
      else if (ped_req)
        ped_latch <= 1'b1;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer with an attached seconds countdown.
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       reset;
  logic [5:0] seconds;
  logic       ped_req;
  logic       emergency;
  logic       loader;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;

  traffic_phase_sequencer dut (
    .InputClk  (clk),
    .reset     (reset),
    .seconds   (seconds),
    .ped_req   (ped_req),
    .emergency (emergency),
    .loader    (loader),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .walk      (walk),
    .phase     (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Countdown: reloads to 15 on a loader strobe, otherwise decrements, on the negedge.
  always @(negedge clk) begin
    if (loader === 1'b1) seconds = 6'd15;
    else                 seconds = seconds - 6'd1;
  end

  typedef struct packed {
    logic [2:0] ph;
    logic       ld;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
  } obs_t;

  typedef struct {
    bit         rst;
    bit         emg;
    bit         ped;
    int         n;
    logic [2:0] ph;
    bit         wk;
  } row_t;

  obs_t exp_q[$];
  row_t rows[25];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_st     = 5;
  int   m_age    = 0;
  bit   m_ped    = 1'b0;

  function automatic int dur(int s);
    case (s)
      0, 3:    return 16;
      1, 4:    return 4;
      6:       return 10;
      default: return 2;
    endcase
  endfunction

  function automatic int succ(int s, bit p);
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 5;
      5: return p ? 6 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t expect_obs(int s, bit ld);
    obs_t o;
    o.ph = 3'(s);
    o.ld = ld;
    o.ns = 3'b100;
    o.ew = 3'b100;
    o.wk = 1'b0;
    case (s)
      0: o.ns = 3'b001;
      1: o.ns = 3'b010;
      3: o.ew = 3'b001;
      4: o.ew = 3'b010;
      6: o.wk = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // Phase model counts edges since entry; a phase exits on its (16 - END)th edge.
  task automatic model_step();
    int nx;
    bit ent;
    if (reset) begin
      m_st  = 5;
      m_age = 0;
      m_ped = 1'b0;
      ent   = 1'b1;
    end else begin
      ent = 1'b0;
      nx  = m_st;
      if (emergency) begin
        nx = 7; ent = 1'b1;
      end else if (m_st == 7) begin
        nx = 5; ent = 1'b1;
      end else begin
        m_age++;
        if (m_age == dur(m_st)) begin
          nx = succ(m_st, m_ped); ent = 1'b1;
        end
      end
      if (ent) m_age = 0;
      if (nx == 6 && m_st != 6) m_ped = 1'b0;
      else if (ped_req)         m_ped = 1'b1;
      m_st = nx;
    end
    exp_q.push_back(expect_obs(m_st, ent));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle();
    obs_t e;
    obs_t a;
    model_step();
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    a = {phase, loader, ns_light, ew_light, walk};
    check("cycle_outputs", 32'(a), 32'(e));
    check("both_axes_go", (ns_light != 3'b100 && ew_light != 3'b100) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic run(input bit r, input bit em, input bit pr, input int n);
    reset     = r;
    emergency = em;
    ped_req   = pr;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    seconds   = 6'd0;
    reset     = 1'b1;
    emergency = 1'b0;
    ped_req   = 1'b0;

    rows[0]  = '{1, 0, 0,  3, 3'd5, 0};  // held in reset
    rows[1]  = '{0, 0, 0,  2, 3'd0, 0};  // all-red exits on second edge
    rows[2]  = '{0, 0, 0, 16, 3'd1, 0};
    rows[3]  = '{0, 0, 0,  4, 3'd2, 0};
    rows[4]  = '{0, 0, 0,  2, 3'd3, 0};
    rows[5]  = '{0, 0, 1,  1, 3'd3, 0};  // ped pulse in EW green
    rows[6]  = '{0, 0, 0, 15, 3'd4, 0};
    rows[7]  = '{0, 0, 0,  4, 3'd5, 0};
    rows[8]  = '{0, 0, 0,  2, 3'd6, 1};
    rows[9]  = '{0, 0, 0, 10, 3'd0, 0};
    rows[10] = '{0, 0, 0, 44, 3'd0, 0};  // full ring, no walk
    rows[11] = '{0, 0, 0,  8, 3'd0, 0};  // seconds now 7
    rows[12] = '{0, 1, 0,  3, 3'd7, 0};
    rows[13] = '{0, 0, 0,  1, 3'd5, 0};
    rows[14] = '{0, 0, 0,  2, 3'd0, 0};
    rows[15] = '{0, 0, 1, 44, 3'd6, 1};  // ped held across walk entry
    rows[16] = '{0, 0, 1,  1, 3'd6, 1};
    rows[17] = '{0, 0, 0,  9, 3'd0, 0};
    rows[18] = '{0, 0, 0, 44, 3'd6, 1};  // re-latched request served
    rows[19] = '{0, 0, 0, 10, 3'd0, 0};
    rows[20] = '{0, 0, 1, 30, 3'd3, 0};
    rows[21] = '{0, 0, 0,  9, 3'd4, 0};
    rows[22] = '{1, 1, 0,  1, 3'd5, 0};  // reset beats emergency
    rows[23] = '{0, 0, 0,  2, 3'd0, 0};
    rows[24] = '{0, 0, 0, 44, 3'd0, 0};  // reset dropped the pending request

    for (int r = 0; r < 25; r++) begin
      run(rows[r].rst, rows[r].emg, rows[r].ped, rows[r].n);
      check($sformatf("row%0d_phase", r), 32'(phase), 32'(rows[r].ph));
      check($sformatf("row%0d_walk", r), 32'(walk), 32'(rows[r].wk));
    end

    // Emergency on the very edge where ALL_RED_A would have exited.
    run(0, 0, 0, 21);
    check("pre_emg_phase", 32'(phase), 32'd2);
    run(0, 1, 0, 1);
    check("emg_on_exit_phase", 32'(phase), 32'd7);
    check("emg_on_exit_loader", 32'(loader), 32'd1);
    check("emg_on_exit_lights", 32'({ns_light, ew_light}), 32'h24);
    run(0, 0, 0, 1);
    check("emg_release_phase", 32'(phase), 32'd5);
    check("emg_release_loader", 32'(loader), 32'd1);
    run(0, 0, 0, 1);
    check("emg_release_armed_loader", 32'(loader), 32'd0);
    run(0, 0, 0, 1);
    check("emg_resume_phase", 32'(phase), 32'd0);
    check("emg_resume_ns", 32'(ns_light), 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
